// File: rtl/pic_decode_seq.sv
// Registered PIC16-style instruction decoder with a per-slot phase sequencer and skip/branch squashing.
// Optional build macro PIC_DEC_ILLEGAL_EN adds a sticky 'illegal' output for unsupported encodings.
module pic_decode_seq #(
    parameter int F_W      = 7,
    parameter int PHASES   = 4,
    parameter int WR_PHASE = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        inst_valid,
    output logic                        inst_ready,
    input  logic [F_W+6:0]              inst_in,
    input  logic                        alu_zero,
    input  logic                        f_bit,
    output logic [$clog2(PHASES)-1:0]   phase,
    output logic                        d,
    output logic                        switch_a_m,
    output logic [3:0]                  alu_op,
    output logic [F_W-1:0]              f_addr,
    output logic [7:0]                  k_lit,
    output logic [2:0]                  bit_number,
    output logic                        wr_en,
    output logic                        branch,
    output logic                        is_call,
    output logic [F_W+3:0]              branch_tgt,
    output logic                        squash
`ifdef PIC_DEC_ILLEGAL_EN
    ,
    output logic                        illegal
`endif
);
    localparam int INST_W = F_W + 7;
    localparam int PH_W   = $clog2(PHASES);
    localparam logic [PH_W-1:0] LAST_PH = PH_W'(PHASES - 1);
    localparam logic [PH_W-1:0] WR_PH   = PH_W'(WR_PHASE);

    localparam logic [1:0] S_WAIT   = 2'd0;
    localparam logic [1:0] S_EXEC   = 2'd1;
    localparam logic [1:0] S_SQUASH = 2'd2;

    localparam logic [1:0] SK_NONE = 2'd0;
    localparam logic [1:0] SK_ZERO = 2'd1;
    localparam logic [1:0] SK_CLR  = 2'd2;
    localparam logic [1:0] SK_SET  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              skip_pend_q, skip_pend_d;
    logic              d_q, d_d;
    logic              sam_q, sam_d;
    logic [3:0]        alu_op_q, alu_op_d;
    logic [F_W-1:0]    f_addr_q, f_addr_d;
    logic [7:0]        k_lit_q, k_lit_d;
    logic [2:0]        bit_number_q, bit_number_d;
    logic              wr_en_q, wr_en_d;
    logic              branch_q, branch_d;
    logic              is_call_q, is_call_d;
    logic [F_W+3:0]    branch_tgt_q, branch_tgt_d;
    logic              squash_q, squash_d;
    logic              writes_q, writes_d;
    logic [1:0]        skip_kind_q, skip_kind_d;
    logic              br_slot_q, br_slot_d;

    logic [3:0] opc;
    logic [3:0] dec_alu_op;
    logic       dec_d, dec_sam, dec_wr, dec_br, dec_call;
    logic [1:0] dec_skip;
    logic       skip_hit;

    assign opc = inst_in[INST_W-3 -: 4];

    always_comb begin
        dec_alu_op = 4'd1;
        dec_d      = 1'b0;
        dec_sam    = 1'b1;
        dec_wr     = 1'b0;
        dec_skip   = SK_NONE;
        dec_br     = 1'b0;
        dec_call   = 1'b0;
        case (inst_in[INST_W-1 -: 2])
            2'b00: begin
                // Only the f destination drives the file write strobe; 0000 with d=0 is NOP.
                dec_d  = inst_in[F_W];
                dec_wr = inst_in[F_W];
                case (opc)
                    4'b0111: dec_alu_op = 4'd2;
                    4'b0101: dec_alu_op = 4'd4;
                    4'b0001: dec_alu_op = 4'd9;
                    4'b1001: dec_alu_op = 4'd12;
                    4'b0011: dec_alu_op = 4'd6;
                    4'b1011: begin dec_alu_op = 4'd6; dec_skip = SK_ZERO; end
                    4'b1010: dec_alu_op = 4'd5;
                    4'b1111: begin dec_alu_op = 4'd5; dec_skip = SK_ZERO; end
                    4'b0100: dec_alu_op = 4'd10;
                    4'b1000: dec_alu_op = 4'd0;
                    4'b1101: dec_alu_op = 4'd8;
                    4'b1100: dec_alu_op = 4'd15;
                    4'b0010: dec_alu_op = 4'd3;
                    4'b1110: dec_alu_op = 4'd11;
                    4'b0110: dec_alu_op = 4'd7;
                    default: dec_alu_op = 4'd1;
                endcase
            end
            2'b01: begin
                dec_d = 1'b1;
                case (inst_in[INST_W-3 -: 2])
                    2'b00:   begin dec_alu_op = 4'd14; dec_wr = 1'b1; end
                    2'b01:   begin dec_alu_op = 4'd13; dec_wr = 1'b1; end
                    2'b10:   dec_skip = SK_CLR;
                    default: dec_skip = SK_SET;
                endcase
            end
            2'b11: begin
                dec_sam = 1'b0;
                casez (opc)
                    4'b00??: dec_alu_op = 4'd0;
                    4'b1000: dec_alu_op = 4'd10;
                    4'b1001: dec_alu_op = 4'd4;
                    4'b1010: dec_alu_op = 4'd7;
                    4'b110?: dec_alu_op = 4'd3;
                    4'b111?: dec_alu_op = 4'd2;
                    default: dec_alu_op = 4'd1;
                endcase
            end
            default: begin
                dec_br   = 1'b1;
                dec_call = ~inst_in[INST_W-3];
            end
        endcase
    end

    assign skip_hit = (state_q == S_EXEC) && (phase_q == WR_PH) &&
                      (br_slot_q ||
                       ((skip_kind_q == SK_ZERO) && alu_zero) ||
                       ((skip_kind_q == SK_CLR) && !f_bit) ||
                       ((skip_kind_q == SK_SET) && f_bit));

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        skip_pend_d  = skip_pend_q | skip_hit;
        d_d          = d_q;
        sam_d        = sam_q;
        alu_op_d     = alu_op_q;
        f_addr_d     = f_addr_q;
        k_lit_d      = k_lit_q;
        bit_number_d = bit_number_q;
        is_call_d    = is_call_q;
        branch_tgt_d = branch_tgt_q;
        squash_d     = squash_q;
        writes_d     = writes_q;
        skip_kind_d  = skip_kind_q;
        br_slot_d    = br_slot_q;
        if (state_q == S_WAIT) begin
            if (inst_valid) begin
                state_d      = skip_pend_q ? S_SQUASH : S_EXEC;
                phase_d      = PH_W'(1);
                skip_pend_d  = 1'b0;
                squash_d     = skip_pend_q;
                d_d          = dec_d;
                sam_d        = dec_sam;
                alu_op_d     = skip_pend_q ? 4'd1 : dec_alu_op;
                f_addr_d     = inst_in[F_W-1:0];
                k_lit_d      = inst_in[7:0];
                bit_number_d = inst_in[F_W+2:F_W];
                is_call_d    = dec_call;
                branch_tgt_d = inst_in[INST_W-4:0];
                writes_d     = dec_wr;
                skip_kind_d  = dec_skip;
                br_slot_d    = dec_br;
            end
        end else if (phase_q == LAST_PH) begin
            state_d  = S_WAIT;
            phase_d  = '0;
            squash_d = 1'b0;
        end else begin
            phase_d = phase_q + PH_W'(1);
        end
        // Strobes are looked up against the next phase so they line up with the phase output.
        wr_en_d  = (state_d == S_EXEC) && (phase_d == WR_PH) && writes_d;
        branch_d = (state_d == S_EXEC) && (phase_d == LAST_PH) && br_slot_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_WAIT;
            phase_q      <= '0;
            skip_pend_q  <= 1'b0;
            d_q          <= 1'b0;
            sam_q        <= 1'b1;
            alu_op_q     <= 4'd1;
            f_addr_q     <= '0;
            k_lit_q      <= '0;
            bit_number_q <= '0;
            wr_en_q      <= 1'b0;
            branch_q     <= 1'b0;
            is_call_q    <= 1'b0;
            branch_tgt_q <= '0;
            squash_q     <= 1'b0;
            writes_q     <= 1'b0;
            skip_kind_q  <= SK_NONE;
            br_slot_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            skip_pend_q  <= skip_pend_d;
            d_q          <= d_d;
            sam_q        <= sam_d;
            alu_op_q     <= alu_op_d;
            f_addr_q     <= f_addr_d;
            k_lit_q      <= k_lit_d;
            bit_number_q <= bit_number_d;
            wr_en_q      <= wr_en_d;
            branch_q     <= branch_d;
            is_call_q    <= is_call_d;
            branch_tgt_q <= branch_tgt_d;
            squash_q     <= squash_d;
            writes_q     <= writes_d;
            skip_kind_q  <= skip_kind_d;
            br_slot_q    <= br_slot_d;
        end
    end

`ifdef PIC_DEC_ILLEGAL_EN
    logic illegal_q, illegal_d;
    logic dec_ill;
    // RETLW and the reserved 0000/d=0/f!=0 form are flagged only when they actually execute.
    assign dec_ill = ((inst_in[INST_W-1 -: 2] == 2'b11) && (opc[3:2] == 2'b01)) ||
                     ((inst_in[INST_W-1 -: 2] == 2'b00) && (opc == 4'b0000) &&
                      !inst_in[F_W] && (inst_in[F_W-1:0] != '0));
    assign illegal_d = illegal_q |
                       ((state_q == S_WAIT) && inst_valid && !skip_pend_q && dec_ill);
    always_ff @(posedge clk) begin
        if (reset) illegal_q <= 1'b0;
        else       illegal_q <= illegal_d;
    end
    assign illegal = illegal_q;
`endif

    assign inst_ready = (state_q == S_WAIT) && !reset;
    assign phase      = phase_q;
    assign d          = d_q;
    assign switch_a_m = sam_q;
    assign alu_op     = alu_op_q;
    assign f_addr     = f_addr_q;
    assign k_lit      = k_lit_q;
    assign bit_number = bit_number_q;
    assign wr_en      = wr_en_q;
    assign branch     = branch_q;
    assign is_call    = is_call_q;
    assign branch_tgt = branch_tgt_q;
    assign squash     = squash_q;
endmodule

// File: tb/tb_pic_decode_seq.sv
// Self-checking bench for pic_decode_seq: directed slots plus random instructions against a slot-level model.
module tb_pic_decode_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        inst_valid;
    logic        inst_ready;
    logic [13:0] inst_in;
    logic        alu_zero;
    logic        f_bit;
    logic [1:0]  phase;
    logic        d;
    logic        switch_a_m;
    logic [3:0]  alu_op;
    logic [6:0]  f_addr;
    logic [7:0]  k_lit;
    logic [2:0]  bit_number;
    logic        wr_en;
    logic        branch;
    logic        is_call;
    logic [10:0] branch_tgt;
    logic        squash;
`ifdef PIC_DEC_ILLEGAL_EN
    logic        illegal;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    bit skip_pend_m = 1'b0;

    // Mnemonic-to-ALU-op tables; -1 marks encodings with no defined op.
    int op00 [16] = '{1, 9, 3, 6, 10, 4, 7, 2, 0, 12, 5, 6, 15, 8, 11, 5};
    int op11 [16] = '{0, 0, 0, 0, 1, 1, 1, 1, 10, 4, 7, -1, 3, 3, 2, 2};
    int op01 [4]  = '{14, 13, 1, 1};

    pic_decode_seq #(.F_W(7), .PHASES(4), .WR_PHASE(2)) dut (
        .clk(clk), .reset(reset), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst_in(inst_in), .alu_zero(alu_zero), .f_bit(f_bit), .phase(phase),
        .d(d), .switch_a_m(switch_a_m), .alu_op(alu_op), .f_addr(f_addr),
        .k_lit(k_lit), .bit_number(bit_number), .wr_en(wr_en), .branch(branch),
        .is_call(is_call), .branch_tgt(branch_tgt), .squash(squash)
`ifdef PIC_DEC_ILLEGAL_EN
        , .illegal(illegal)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // sk: 0 none, 1 skip on zero, 2 skip if bit clear, 3 skip if bit set
    task automatic ref_dec(input logic [13:0] ins, output int op, output int dd, output int sam,
                           output bit wr, output int sk, output bit br);
        op = -1; dd = -1; sam = -1; wr = 1'b0; sk = 0; br = 1'b0;
        case (ins[13:12])
            2'b00: begin
                op = op00[int'(ins[11:8])]; dd = int'(ins[7]); sam = 1; wr = ins[7];
                sk = (ins[11:8] == 4'b1011 || ins[11:8] == 4'b1111) ? 1 : 0;
            end
            2'b01: begin
                op = op01[int'(ins[11:10])]; dd = 1; sam = 1; wr = !ins[11];
                sk = ins[11] ? (ins[10] ? 3 : 2) : 0;
            end
            2'b11: begin op = op11[int'(ins[11:8])]; dd = 0; sam = 0; end
            default: br = 1'b1;
        endcase
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_ready"}, 32'(inst_ready), 0);
        chk({tag, "_phase"}, 32'(phase), 0);
        chk({tag, "_d"}, 32'(d), 0);
        chk({tag, "_sam"}, 32'(switch_a_m), 1);
        chk({tag, "_aluop"}, 32'(alu_op), 1);
        chk({tag, "_faddr"}, 32'(f_addr), 0);
        chk({tag, "_k"}, 32'(k_lit), 0);
        chk({tag, "_bitn"}, 32'(bit_number), 0);
        chk({tag, "_wr"}, 32'(wr_en), 0);
        chk({tag, "_br"}, 32'(branch), 0);
        chk({tag, "_call"}, 32'(is_call), 0);
        chk({tag, "_tgt"}, 32'(branch_tgt), 0);
        chk({tag, "_sq"}, 32'(squash), 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            chk("idle_phase", 32'(phase), 0);
            chk("idle_wr", 32'(wr_en), 0);
            chk("idle_ready", 32'(inst_ready), 1);
            tick();
        end
    endtask

    // Runs one full slot from WAIT back to WAIT; az/fb are what the ALU reports in the write phase.
    task automatic run_slot(input logic [13:0] ins, input bit az, input bit fb);
        int op, dd, sam, sk;
        bit wr, br, sq, hit;
        ref_dec(ins, op, dd, sam, wr, sk, br);
        sq = skip_pend_m;
        skip_pend_m = 1'b0;
        $display("slot inst=%h az=%0d fb=%0d expect_squash=%0d", ins, az, fb, sq);
        chk("cap_ready", 32'(inst_ready), 1);
        chk("cap_phase", 32'(phase), 0);
        inst_valid = 1'b1;
        inst_in = ins;
        tick();
        inst_valid = 1'b0;
        inst_in = 14'($urandom);
        for (int p = 1; p <= 3; p++) begin
            alu_zero = (p == 2) ? az : 1'($urandom);
            f_bit    = (p == 2) ? fb : 1'($urandom);
            chk("phase", 32'(phase), 32'(p));
            chk("squash", 32'(squash), 32'(sq));
            chk("wr_en", 32'(wr_en), 32'(!sq && p == 2 && wr));
            chk("branch", 32'(branch), 32'(!sq && p == 3 && br));
            chk("ready", 32'(inst_ready), 0);
            if (sq) chk("sq_aluop", 32'(alu_op), 1);
            else if (op >= 0) chk("alu_op", 32'(alu_op), 32'(op));
            if (p == 1 && !sq) begin
                if (dd >= 0) chk("d", 32'(d), 32'(dd));
                if (sam >= 0) chk("sam", 32'(switch_a_m), 32'(sam));
                if (ins[13:12] != 2'b10) chk("f_addr", 32'(f_addr), 32'(ins[6:0]));
                if (ins[13:12] == 2'b11) chk("k_lit", 32'(k_lit), 32'(ins[7:0]));
                if (ins[13:12] == 2'b01) chk("bitn", 32'(bit_number), 32'(ins[9:7]));
            end
            if (p == 3 && !sq && br) begin
                chk("is_call", 32'(is_call), 32'(!ins[11]));
                chk("tgt", 32'(branch_tgt), 32'(ins[10:0]));
            end
            tick();
        end
        hit = br || (sk == 1 && az) || (sk == 2 && !fb) || (sk == 3 && fb);
        if (!sq && hit) skip_pend_m = 1'b1;
        chk("end_phase", 32'(phase), 0);
        chk("end_sq", 32'(squash), 0);
        chk("end_wr", 32'(wr_en), 0);
        chk("end_br", 32'(branch), 0);
        if (sq) chk("hold_aluop", 32'(alu_op), 1);
        else if (op >= 0) chk("hold_aluop", 32'(alu_op), 32'(op));
    endtask

    initial begin
        reset = 1'b1; inst_valid = 1'b0; inst_in = '0; alu_zero = 1'b0; f_bit = 1'b0;
        repeat (3) tick();
        check_reset("rst");
        reset = 1'b0;
        tick();

        // ADDWF, then ADDLW (literal to W must not strobe the file)
        run_slot(14'h07A0, 1'b0, 1'b0);
        chk("addwf_faddr", 32'(f_addr), 32'h20);
        run_slot(14'h3E05, 1'b1, 1'b1);
        chk("addlw_k", 32'(k_lit), 32'h05);

        // DECFSZ reaching zero squashes the following ADDWF; third slot runs normally
        run_slot(14'h0BA0, 1'b1, 1'b0);
        run_slot(14'h07A0, 1'b0, 1'b0);
        run_slot(14'h07A0, 1'b0, 1'b0);
        run_slot(14'h0BA0, 1'b0, 1'b1);
        run_slot(14'h07A0, 1'b0, 1'b0);

        // BTFSS with bit set skips; with bit clear it does not
        run_slot(14'h1DA0, 1'b0, 1'b1);
        chk("btfss_bitn", 32'(bit_number), 3);
        run_slot(14'h07A0, 1'b0, 1'b0);
        run_slot(14'h1DA0, 1'b1, 1'b0);
        run_slot(14'h07A0, 1'b0, 1'b0);

        // GOTO, an idle gap that must keep the pending squash, then the squashed slot
        run_slot(14'h2855, 1'b0, 1'b0);
        chk("goto_tgt", 32'(branch_tgt), 32'h055);
        idle(3);
        run_slot(14'h07A0, 1'b0, 1'b0);

        // Reset in phase 2 of a skipping DECFSZ, with valid high during reset
        inst_valid = 1'b1; inst_in = 14'h0BA0;
        tick();
        inst_valid = 1'b0;
        tick();
        chk("mid_phase", 32'(phase), 2);
        alu_zero = 1'b1; reset = 1'b1; inst_valid = 1'b1; inst_in = 14'h07A0;
        tick();
        check_reset("midrst");
        reset = 1'b0; inst_valid = 1'b0;
        tick();
        chk("not_consumed", 32'(phase), 0);
        skip_pend_m = 1'b0;
        run_slot(14'h07A0, 1'b0, 1'b0);

        for (int i = 0; i < 80; i++) begin
            logic [13:0] ins;
            ins = 14'($urandom);
            if ($urandom_range(0, 3) == 0) ins[13:12] = 2'b01;
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            run_slot(ins, 1'($urandom), 1'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
